// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  // EX operand source selects.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // Bundle of every pipeline-register control produced each cycle.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  // Normal flow: everything advances, nothing squashed.
  localparam ctrl_t CTRL_FLOW     = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                      id_ex_write: 1'b1, id_ex_bubble: 1'b0,
                                      ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
  // Whole pipe held while data memory is busy; WB receives a bubble.
  localparam ctrl_t CTRL_FREEZE   = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_write: 1'b0, id_ex_bubble: 1'b0,
                                      ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};
  // Taken branch: fetch the target, squash the two wrong-path instructions.
  localparam ctrl_t CTRL_BRANCH   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                      id_ex_write: 1'b1, id_ex_bubble: 1'b1,
                                      ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
  // Load-use: hold PC and IF/ID, insert one bubble into EX, let the load advance.
  localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_write: 1'b1, id_ex_bubble: 1'b1,
                                      ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
  // Reset: nothing loads, every stage register is cleared to a NOP.
  localparam ctrl_t CTRL_RESET    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                      id_ex_write: 1'b0, id_ex_bubble: 1'b1,
                                      ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding selects. EX/MEM has priority over MEM/WB
// because it holds the younger result; register 0 is never forwarded.
module forwarding_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  function automatic logic [1:0] pick_src(input logic [REG_ADDR_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Both operands use the same priority rule against their own specifier.
  always_comb begin
    fwd_a = pick_src(ex_rs);
    fwd_b = pick_src(ex_rt);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: load-use stall, branch flush,
// memory-wait freeze with timeout fault, operand forwarding, stall counter.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_write,
  output logic                  mem_wb_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_fault,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [1:0]            dbg_state
);

  // Handshake: mem_req is held by the MEM stage for the whole access and
  // mem_ready pulses for the single cycle in which the access completes;
  // the pipe is frozen on every cycle with mem_req=1 and mem_ready=0.

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_fault_q, mem_fault_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic  load_use;
  ctrl_t flow_ctrl;
  ctrl_t ctrl;

  forwarding_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd (
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  end

  // Controls when memory is not stalling: a branch beats load-use because
  // the dependent instruction in ID is on the wrong path.
  always_comb begin
    flow_ctrl = CTRL_FLOW;
    if (branch_taken) begin
      flow_ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      flow_ctrl = CTRL_LOAD_USE;
    end
  end

  // Sequencer next-state and zero-latency control outputs.
  always_comb begin
    ctrl        = CTRL_FLOW;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          // Branch is ignored: EX is held and the branch re-resolves on release.
          ctrl       = CTRL_FREEZE;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          ctrl = flow_ctrl;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d     = FAULT;
            mem_fault_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end
        end else begin
          ctrl       = flow_ctrl;
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      FAULT: begin
        ctrl        = CTRL_FREEZE;
        mem_fault_d = 1'b1;
      end
      default: begin
        ctrl    = CTRL_FREEZE;
        state_d = RUN;
      end
    endcase
    if (reset) begin
      ctrl = CTRL_RESET;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!ctrl.pc_write && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // Registered sequencer state; reset returns to RUN from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_fault_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_fault_q    <= mem_fault_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Drive the flat output ports from the control bundle and registers.
  always_comb begin
    pc_write      = ctrl.pc_write;
    if_id_write   = ctrl.if_id_write;
    if_id_flush   = ctrl.if_id_flush;
    id_ex_write   = ctrl.id_ex_write;
    id_ex_bubble  = ctrl.id_ex_bubble;
    ex_mem_write  = ctrl.ex_mem_write;
    mem_wb_bubble = ctrl.mem_wb_bubble;
    mem_fault     = mem_fault_q;
    stall_cycles  = stall_cycles_q;
    dbg_state     = state_q;
  end

endmodule
